// File: rtl/imem_loader.sv
// Instruction memory write side: a byte-stream program loader plus a
// combinational 10-byte little-endian fetch window with range checking.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int LEN_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_start_i,
  input  logic [63:0]      load_base_i,
  input  logic [LEN_W-1:0] load_len_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             load_busy_o,
  output logic             load_done_o,
  output logic             load_error_o,
  input  logic [63:0]      rd_addr_i,
  output logic [79:0]      rd_bytes_o,
  output logic             rd_error_o
);

  localparam int          AW     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MEM_SZ = 64'(MEM_BYTES);
  localparam logic [63:0] RD_MAX = 64'(MEM_BYTES - 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              wr_en;
  logic              reject;
  logic [7:0]        mem_q [MEM_BYTES];

  // Range check written as len > MEM-base so a huge base cannot wrap past zero.
  assign reject = (load_base_i > MEM_SZ) ||
                  (64'(load_len_i) > (MEM_SZ - load_base_i));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          if (reject) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (load_len_i == '0) begin
            err_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            ptr_d   = load_base_i[AW-1:0];
            count_d = load_len_i;
            err_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (byte_valid_i) begin
          wr_en   = !rst_i;
          ptr_d   = ptr_q + AW'(1);
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Array contents deliberately survive reset so a partial load stays readable.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[ptr_q] <= byte_data_i;
  end

  assign byte_ready_o = (state_q == S_RUN);
  assign load_busy_o  = (state_q != S_IDLE);
  assign load_done_o  = done_q | (state_q == S_DONE);
  assign load_error_o = err_q;

  assign rd_error_o = (rd_addr_i > RD_MAX);

  always_comb begin
    rd_bytes_o = '0;
    if (!rd_error_o) begin
      for (int k = 0; k < 10; k++) begin
        rd_bytes_o[8*k +: 8] = mem_q[rd_addr_i[AW-1:0] + AW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: written bytes are queued as expectations
// and read back through the fetch window at the end.
module tb_imem_loader;

  localparam int MEM = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [63:0] load_base;
  logic [15:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic [63:0] rd_addr;
  logic [79:0] rd_bytes;
  logic        rd_error;

  int checks = 0;
  int errors = 0;
  logic [71:0] sb [$];

  imem_loader #(.MEM_BYTES(MEM), .LEN_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_start_i (load_start),
    .load_base_i  (load_base),
    .load_len_i   (load_len),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .load_busy_o  (load_busy),
    .load_done_o  (load_done),
    .load_error_o (load_error),
    .rd_addr_i    (rd_addr),
    .rd_bytes_o   (rd_bytes),
    .rd_error_o   (rd_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [63:0] base, input logic [15:0] len);
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [63:0] addr, input logic [7:0] data);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = data;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!byte_ready) begin
      check("ready_timeout", {79'd0, byte_ready}, 80'd1);
    end else begin
      tick();
      sb.push_back({addr, data});
    end
    byte_valid = 1'b0;
  endtask

  task automatic drain();
    logic [71:0] e;
    logic [63:0] a, b;
    int off;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      a   = e[71:8];
      b   = (a > 64'(MEM - 10)) ? 64'(MEM - 10) : a;
      off = int'(a - b);
      rd_addr = b;
      #1;
      check("sb_byte", {72'd0, rd_bytes[8*off +: 8]}, {72'd0, e[7:0]});
    end
  endtask

  initial begin
    logic [79:0] exp_win;
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    byte_valid = 1'b0; byte_data = '0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy",  {79'd0, load_busy},  80'd0);
    check("rst_ready", {79'd0, byte_ready}, 80'd0);
    check("rst_done",  {79'd0, load_done},  80'd0);
    check("rst_error", {79'd0, load_error}, 80'd0);

    // basic three-byte load with valid held
    start(64'd0, 16'd3);
    check("t1_ready", {79'd0, byte_ready}, 80'd1);
    check("t1_busy",  {79'd0, load_busy},  80'd1);
    send(64'd0, 8'h30);
    check("t1_nodone", {79'd0, load_done}, 80'd0);
    send(64'd1, 8'hF4);
    send(64'd2, 8'h0A);
    check("t1_done",    {79'd0, load_done},  80'd1);
    check("t1_ready_lo",{79'd0, byte_ready}, 80'd0);
    tick();
    check("t1_done_lo", {79'd0, load_done}, 80'd0);
    check("t1_idle",    {79'd0, load_busy}, 80'd0);
    rd_addr = 64'd0; #1;
    check("t1_window", {56'd0, rd_bytes[23:0]}, {56'd0, 24'h0AF430});

    // sentinel at 30, then a gapped 10-byte load at 20
    start(64'd30, 16'd1);
    send(64'd30, 8'hEE);
    tick();
    start(64'd20, 16'd10);
    for (int k = 0; k < 10; k++) begin
      send(64'(20 + k), 8'(8'h50 + k));
      if (k < 9) begin
        tick();
        check("t2_ready_gap", {79'd0, byte_ready}, 80'd1);
      end
    end
    check("t2_done", {79'd0, load_done}, 80'd1);
    tick();
    check("t2_idle", {79'd0, load_busy}, 80'd0);
    for (int k = 0; k < 10; k++) exp_win[8*k +: 8] = 8'(8'h50 + k);
    rd_addr = 64'd20; #1;
    check("t2_window", rd_bytes, exp_win);
    rd_addr = 64'd30; #1;
    check("t2_sentinel", {72'd0, rd_bytes[7:0]}, {72'd0, 8'hEE});

    // out-of-range load rejected, memory untouched
    start(64'(MEM - 2), 16'd2);
    check("t3_ok_err", {79'd0, load_error}, 80'd0);
    send(64'(MEM - 2), 8'hAA);
    send(64'(MEM - 1), 8'hBB);
    tick();
    byte_valid = 1'b1; byte_data = 8'h11;
    start(64'(MEM - 2), 16'd3);
    check("t3_err",   {79'd0, load_error}, 80'd1);
    check("t3_done",  {79'd0, load_done},  80'd1);
    check("t3_busy",  {79'd0, load_busy},  80'd0);
    check("t3_ready", {79'd0, byte_ready}, 80'd0);
    tick();
    byte_valid = 1'b0;
    check("t3_done_lo", {79'd0, load_done},  80'd0);
    check("t3_sticky",  {79'd0, load_error}, 80'd1);
    rd_addr = 64'(MEM - 10); #1;
    check("t3_mem", {64'd0, rd_bytes[79:64]}, {64'd0, 16'hBBAA});
    start(64'(MEM + 1), 16'd0);
    check("t3_base_over", {79'd0, load_error}, 80'd1);
    start(64'(MEM), 16'd0);
    check("t3_clear", {79'd0, load_error}, 80'd0);
    check("t3_clear_done", {79'd0, load_done}, 80'd1);
    tick();

    // fetch window range edge
    rd_addr = 64'(MEM - 10); #1;
    check("t4_edge_ok", {79'd0, rd_error}, 80'd0);
    rd_addr = 64'(MEM - 9); #1;
    check("t4_edge_err", {79'd0, rd_error}, 80'd1);
    check("t4_edge_zero", rd_bytes, 80'd0);
    rd_addr = '1; #1;
    check("t4_max_err", {79'd0, rd_error}, 80'd1);

    // reset mid-load, then a start pulse during RUN
    start(64'd100, 16'd5);
    send(64'd100, 8'hC1);
    send(64'd101, 8'hC2);
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h77;
    tick();
    rst = 1'b0; byte_valid = 1'b0;
    check("t5_busy",  {79'd0, load_busy},  80'd0);
    check("t5_ready", {79'd0, byte_ready}, 80'd0);
    check("t5_done",  {79'd0, load_done},  80'd0);
    tick();
    check("t5_nodone", {79'd0, load_done}, 80'd0);
    start(64'd200, 16'd3);
    send(64'd200, 8'hD0);
    load_start = 1'b1; load_base = 64'd300; load_len = 16'd1;
    send(64'd201, 8'hD1);
    load_start = 1'b0;
    check("t5_ign_ready", {79'd0, byte_ready}, 80'd1);
    check("t5_ign_done",  {79'd0, load_done},  80'd0);
    send(64'd202, 8'hD2);
    check("t5_ign_end", {79'd0, load_done}, 80'd1);
    tick();

    // zero-length load
    start(64'd5, 16'd0);
    check("t6_done",  {79'd0, load_done},  80'd1);
    check("t6_busy",  {79'd0, load_busy},  80'd0);
    check("t6_error", {79'd0, load_error}, 80'd0);
    tick();
    check("t6_done_lo", {79'd0, load_done}, 80'd0);
    check("t6_busy_lo", {79'd0, load_busy}, 80'd0);

    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
